// File: rtl/paddsb_pkg.sv
// Shared lane geometry and saturation constants for the packed saturating adder.
// Pure definitions; no logic, no latency, no backpressure.
// Imported by the lane adder and the 16-bit top.
package paddsb_pkg;

  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t SAT_POS = 4'h7;
  localparam lane_t SAT_NEG = 4'h8;

endpackage

// File: rtl/sat_add_4bit.sv
// One 4-bit two's-complement lane adder with signed saturation.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs.
module sat_add_4bit
  import paddsb_pkg::*;
(
  input  lane_t a,
  input  lane_t b,
  output lane_t sum,
  output logic  sat
);

  lane_t g;
  lane_t p;
  lane_t c;
  lane_t s;
  logic  pos_ovf;
  logic  neg_ovf;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries; carry-in is zero so lanes never chain.
  assign c[0] = 1'b0;
  assign c[1] = g[0];
  assign c[2] = g[1] | (p[1] & g[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);

  assign s = p ^ c;

  assign pos_ovf = ~a[3] & ~b[3] &  s[3];
  assign neg_ovf =  a[3] &  b[3] & ~s[3];

  always_comb begin
    sum = s;
    sat = 1'b0;
    if (pos_ovf) begin
      sum = SAT_POS;
      sat = 1'b1;
    end else if (neg_ovf) begin
      sum = SAT_NEG;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/paddsb_16bit.sv
// Packed 4x4-bit saturating adder with per-lane saturation flags.
// Latency: 1 cycle (registered Sum/Sat), new result every cycle.
// Backpressure: none; no enable or handshake.
module paddsb_16bit
  import paddsb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANE_W*NUM_LANES-1:0] A,
  input  logic [LANE_W*NUM_LANES-1:0] B,
  output logic [LANE_W*NUM_LANES-1:0] Sum,
  output logic [NUM_LANES-1:0]        Sat
);

  logic [LANE_W*NUM_LANES-1:0] lane_sum;
  logic [NUM_LANES-1:0]        lane_sat;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sat_add_4bit u_lane (
      .a   (A[LANE_W*i +: LANE_W]),
      .b   (B[LANE_W*i +: LANE_W]),
      .sum (lane_sum[LANE_W*i +: LANE_W]),
      .sat (lane_sat[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum <= '0;
      Sat <= '0;
    end else begin
      Sum <= lane_sum;
      Sat <= lane_sat;
    end
  end

endmodule

// File: tb/tb_paddsb_16bit.sv
// Directed-vector bench for paddsb_16bit with hand-computed expectations.
module tb_paddsb_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Sum;
  logic [3:0]  Sat;

  int n_tests;
  int n_fail;

  paddsb_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .Sat   (Sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a vector away from the edge, then check it one rising edge later.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_sum, input logic [3:0] exp_sat);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check({tag, "_sum"}, Sum, exp_sum);
    check({tag, "_sat"}, {12'h000, Sat}, {12'h000, exp_sat});
  endtask

  // Back-to-back stream: {A, B, Sum, Sat}
  localparam int NSTR = 5;
  logic [15:0] str_a   [NSTR] = '{16'h1234, 16'h7777, 16'h8F88, 16'h4444, 16'h8000};
  logic [15:0] str_b   [NSTR] = '{16'h1111, 16'h1111, 16'h8F88, 16'hEEEE, 16'hF000};
  logic [15:0] str_sum [NSTR] = '{16'h2345, 16'h7777, 16'h8E88, 16'h2222, 16'h8000};
  logic [3:0]  str_sat [NSTR] = '{4'b0000, 4'b1111, 4'b1011, 4'b0000, 4'b1000};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    A       = 16'h1234;
    B       = 16'h1111;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", Sum, 16'h0000);
    check("rst_sat", {12'h000, Sat}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_sum", Sum, 16'h2345);
    check("first_sat", {12'h000, Sat}, 16'h0000);

    apply("pos_sat",   16'h7777, 16'h1111, 16'h7777, 4'b1111);
    apply("exact_fit", 16'h7654, 16'h0123, 16'h7777, 4'b0000);
    apply("neg_mixed", 16'h8F88, 16'h8F88, 16'h8E88, 4'b1011);
    apply("opp_sign1", 16'h7777, 16'h8888, 16'hFFFF, 4'b0000);
    apply("opp_sign2", 16'h8888, 16'h7777, 16'hFFFF, 4'b0000);
    apply("opp_sign3", 16'h4444, 16'hEEEE, 16'h2222, 4'b0000);
    // -1 + 1 in lanes 0 and 2 wraps to 0 with no carry into lanes 1 and 3.
    apply("isolate1",  16'h0F0F, 16'h0101, 16'h0000, 4'b0000);
    apply("isolate2",  16'h8000, 16'hF000, 16'h8000, 4'b1000);

    // Streaming: outputs hold the previous result until the next edge.
    @(posedge clk);
    #1;
    for (int i = 0; i < NSTR; i++) begin
      A = str_a[i];
      B = str_b[i];
      #1;
      if (i > 0) check($sformatf("hold%0d", i), Sum, str_sum[i-1]);
      @(posedge clk);
      #1;
      check($sformatf("str%0d_sum", i), Sum, str_sum[i]);
      check($sformatf("str%0d_sat", i), {12'h000, Sat}, {12'h000, str_sat[i]});
    end

    // Asynchronous reset between edges clears outputs immediately.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", Sum, 16'h0000);
    check("async_rst_sat", {12'h000, Sat}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_sum", Sum, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h7777;
    B = 16'h1111;
    @(posedge clk);
    #1;
    check("post_rst_sum", Sum, 16'h7777);
    check("post_rst_sat", {12'h000, Sat}, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
